// File: rtl/exp_seq_pkg.sv
// Shared types and code points for the exponent sequencer.
// Holds the state encoding, op codes, datapath function codes and loop limits.
package exp_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CMP,
      S_ALIGN,
      S_MULX,
      S_NORM,
      S_REMLP,
      S_FIN
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_REM = 3'd4;

   localparam logic [3:0] EF_NOP     = 4'd0;
   localparam logic [3:0] EF_LOAD    = 4'd1;
   localparam logic [3:0] EF_CMP     = 4'd2;
   localparam logic [3:0] EF_SUB     = 4'd3;
   localparam logic [3:0] EF_ADDX    = 4'd4;
   localparam logic [3:0] EF_SUBX    = 4'd5;
   localparam logic [3:0] EF_DEC     = 4'd6;
   localparam logic [3:0] EF_REMSTEP = 4'd8;
   localparam logic [3:0] EF_SUBR    = 4'd9;

   localparam logic [2:0] SF_HOLD   = 3'd0;
   localparam logic [2:0] SF_LDDIFF = 3'd1;
   localparam logic [2:0] SF_ZERO   = 3'd2;
   localparam logic [2:0] SF_PRI    = 3'd3;
   localparam logic [2:0] SF_SAT    = 3'd4;

   localparam int NORM_MAX_DEF = 54;
   localparam int REM_MAX_DEF  = 63;

endpackage

// File: rtl/exp_seq_if.sv
// Request/status bundle between the FPU control and the exponent sequencer.
// The master drives requests and datapath flags; the slave (sequencer) drives codes and status.
interface exp_seq_if;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_code;
   logic       fpuhold;
   logic       le;
   logic       rsge64;
   logic       norm_done;
   logic [3:0] expfunc;
   logic [2:0] safunc;
   logic       busy;
   logic       done;
   logic       op_err;
   logic [5:0] iter;

   modport master (
      output op_valid, op_code, fpuhold, le, rsge64, norm_done,
      input  op_ready, expfunc, safunc, busy, done, op_err, iter
   );

   modport slave (
      input  op_valid, op_code, fpuhold, le, rsge64, norm_done,
      output op_ready, expfunc, safunc, busy, done, op_err, iter
   );
endinterface

// File: rtl/exp_seq_cnt.sv
// Saturating 6-bit loop counter: clear wins over enable, hold freezes everything.
// o_last flags that an enabled count in this cycle reaches i_limit.
module exp_seq_cnt (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_hold,
   input  logic [5:0] i_limit,
   output logic [5:0] o_cnt,
   output logic       o_last
);
   logic [5:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (!i_hold) begin
         if (i_clr) begin
            r_cnt <= '0;
         end else if (i_en && (r_cnt < i_limit)) begin
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (({1'b0, r_cnt} + 7'd1) >= {1'b0, i_limit});
endmodule

// File: rtl/exp_seq.sv
// Exponent-path sequencer for ADD/SUB/MUL/DIV/REM; one op in flight, fpuhold freezes it.
// REM looping is built only when EXP_SEQ_REM_EN is defined; otherwise REM reports op_err.
module exp_seq
   import exp_seq_pkg::*;
#(
   parameter int NORM_MAX = NORM_MAX_DEF,
   parameter int REM_MAX  = REM_MAX_DEF
) (
   input  logic     i_clk,
   input  logic     i_reset,
   exp_seq_if.slave io_seq
);
   localparam logic [5:0] NORM_LIM = NORM_MAX[5:0];

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_op;
   logic       r_err;
   logic       w_err_nxt;
   logic       w_hold;
   logic       w_accept;
   logic       w_fin;
   logic [3:0] w_expfunc;
   logic [2:0] w_safunc;
   logic [5:0] w_norm_cnt;
   logic       w_norm_flag;
   logic       w_norm_last;

   assign w_hold          = io_seq.fpuhold;
   assign io_seq.op_ready = (r_state == S_IDLE) && !w_hold;
   assign w_accept        = io_seq.op_valid && io_seq.op_ready;

   exp_seq_cnt u_norm_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_accept),
      .i_en    ((r_state == S_NORM) && !io_seq.norm_done),
      .i_hold  (w_hold),
      .i_limit (NORM_LIM),
      .o_cnt   (w_norm_cnt),
      .o_last  (w_norm_flag)
   );
   // Second term only guards against a counter already parked at the limit.
   assign w_norm_last = w_norm_flag || (w_norm_cnt >= NORM_LIM);

`ifdef EXP_SEQ_REM_EN
   localparam logic [5:0] REM_LIM = REM_MAX[5:0];
   logic [5:0] w_iter;
   logic       w_iter_last;

   exp_seq_cnt u_iter_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_accept),
      .i_en    ((r_state == S_REMLP) && !io_seq.le),
      .i_hold  (w_hold),
      .i_limit (REM_LIM),
      .o_cnt   (w_iter),
      .o_last  (w_iter_last)
   );
   assign io_seq.iter = w_iter;
`else
   assign io_seq.iter = '0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_err   <= 1'b0;
      end else if (!w_hold) begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
         if (w_accept) begin
            r_op <= io_seq.op_code;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err;
      w_expfunc   = EF_NOP;
      w_safunc    = SF_HOLD;
      w_fin       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_LOAD;
               w_err_nxt   = 1'b0;
            end
         end
         S_LOAD: begin
            w_expfunc = EF_LOAD;
            w_safunc  = SF_ZERO;
            case (r_op)
               OP_ADD, OP_SUB: w_state_nxt = S_CMP;
               OP_MUL, OP_DIV: w_state_nxt = S_MULX;
`ifdef EXP_SEQ_REM_EN
               OP_REM:         w_state_nxt = S_REMLP;
`endif
               default: begin
                  w_state_nxt = S_FIN;
                  w_err_nxt   = 1'b1;
               end
            endcase
         end
         S_CMP: begin
            w_expfunc   = EF_CMP;
            w_state_nxt = S_ALIGN;
         end
         S_ALIGN: begin
            w_expfunc   = io_seq.le ? EF_SUBR : EF_SUB;
            w_safunc    = io_seq.rsge64 ? SF_SAT : SF_LDDIFF;
            w_state_nxt = S_NORM;
         end
         S_MULX: begin
            w_expfunc   = (r_op == OP_DIV) ? EF_SUBX : EF_ADDX;
            w_state_nxt = S_NORM;
         end
         S_NORM: begin
            w_expfunc = EF_DEC;
            w_safunc  = SF_PRI;
            if (io_seq.norm_done) begin
               w_state_nxt = S_FIN;
            end else if (w_norm_last) begin
               w_state_nxt = S_FIN;
               w_err_nxt   = 1'b1;
            end
         end
`ifdef EXP_SEQ_REM_EN
         S_REMLP: begin
            if (io_seq.le) begin
               w_state_nxt = S_NORM;
            end else begin
               w_expfunc = EF_REMSTEP;
               if (w_iter_last) begin
                  w_state_nxt = S_FIN;
                  w_err_nxt   = 1'b1;
               end
            end
         end
`endif
         S_FIN: begin
            w_fin       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Done is masked while stalled so a held FIN still pulses exactly once.
   assign io_seq.expfunc = w_expfunc;
   assign io_seq.safunc  = w_safunc;
   assign io_seq.busy    = (r_state != S_IDLE);
   assign io_seq.done    = w_fin && !w_hold;
   assign io_seq.op_err  = w_fin && !w_hold && r_err;
endmodule

// File: tb/tb_exp_seq.sv
// Randomized scoreboard bench for exp_seq: a cycle plan per op is derived from the op rules,
// inputs are driven from it and a negedge monitor compares every busy cycle.
module tb_exp_seq;

   localparam int NMAX = 54;
   localparam int RMAX = 63;
`ifdef EXP_SEQ_REM_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif

   typedef struct {
      int ef;
      int sf;
      int dn;
      int er;
      int it;
      bit le;
      bit rs;
      bit nd;
      bit hold;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exp_seq_if bus();

   exp_seq #(.NORM_MAX(NMAX), .REM_MAX(RMAX)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .io_seq  (bus)
   );

   int   checks = 0;
   int   errors = 0;
   ent_t plan[$];
   ent_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(int ef, int sf, int dn, int er, int it, int le, int rs, int nd);
      ent_t e;
      e.ef = ef; e.sf = sf; e.dn = dn; e.er = er; e.it = it;
      e.le = (le < 0) ? 1'($urandom_range(0, 1)) : 1'(le);
      e.rs = (rs < 0) ? 1'($urandom_range(0, 1)) : 1'(rs);
      e.nd = (nd < 0) ? 1'($urandom_range(0, 1)) : 1'(nd);
      e.hold = 1'b0;
      return e;
   endfunction

   // Expected per-cycle behaviour after accept, straight from the op rules.
   task automatic build_plan(input int op, input int le_al, input int rs, input int nwait, input int rwait);
      int  it;
      bit  err;
      bit  norm;
      int  steps;
      it = 0; err = 0; norm = 0;
      plan.delete();
      plan.push_back(mk(1, 2, 0, 0, 0, -1, -1, -1));
      if (op == 0 || op == 1) begin
         plan.push_back(mk(2, 0, 0, 0, 0, -1, -1, -1));
         plan.push_back(mk(le_al != 0 ? 9 : 3, rs != 0 ? 4 : 1, 0, 0, 0, le_al, rs, -1));
         norm = 1;
      end else if (op == 2 || op == 3) begin
         plan.push_back(mk(op == 3 ? 5 : 4, 0, 0, 0, 0, -1, -1, -1));
         norm = 1;
      end else if (op == 4 && REM_EN) begin
         steps = (rwait < RMAX) ? rwait : RMAX;
         for (int s = 0; s < steps; s++) plan.push_back(mk(8, 0, 0, 0, s, 0, -1, -1));
         if (rwait >= RMAX) begin
            it = RMAX; err = 1;
         end else begin
            it = rwait;
            plan.push_back(mk(0, 0, 0, 0, it, 1, -1, -1));
            norm = 1;
         end
      end else begin
         err = 1;
      end
      if (norm) begin
         if (nwait < NMAX) begin
            for (int k = 0; k < nwait; k++) plan.push_back(mk(6, 3, 0, 0, it, -1, -1, 0));
            plan.push_back(mk(6, 3, 0, 0, it, -1, -1, 1));
         end else begin
            for (int k = 0; k < NMAX; k++) plan.push_back(mk(6, 3, 0, 0, it, -1, -1, 0));
            err = 1;
         end
      end
      plan.push_back(mk(0, 0, 1, int'(err), it, -1, -1, -1));
   endtask

   // A stall repeats the stalled cycle's outputs, with no completion pulse.
   task automatic add_hold(input int at, input int len);
      ent_t e;
      if (len <= 0) return;
      if (at < 0) at = $urandom_range(0, plan.size() - 1);
      e = plan[at];
      e.dn = 0; e.er = 0; e.hold = 1'b1;
      for (int k = 0; k < len; k++) plan.insert(at, e);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_err"}, int'(bus.op_err), 0);
      chk({tag, "_expfunc"}, int'(bus.expfunc), 0);
      chk({tag, "_safunc"}, int'(bus.safunc), 0);
      chk({tag, "_iter"}, int'(bus.iter), 0);
      chk({tag, "_ready"}, int'(bus.op_ready), 1);
   endtask

   // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
   task automatic run_op(input int op, input int le_al, input int rs, input int nwait,
                         input int rwait, input int hold_at, input int hold_len, input int rst_at);
      build_plan(op, le_al, rs, nwait, rwait);
      add_hold(hold_at, hold_len);
      bus.op_valid = 1'b1;
      bus.op_code = 3'(op);
      bus.fpuhold = 1'b0;
      bus.le = 1'($urandom_range(0, 1));
      bus.norm_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("accept_ready", int'(bus.op_ready), 1);
      foreach (plan[i]) exp_q.push_back(plan[i]);
      foreach (plan[i]) begin
         @(posedge clk); #1;
         bus.le = plan[i].le;
         bus.rsge64 = plan[i].rs;
         bus.norm_done = plan[i].nd;
         bus.fpuhold = plan[i].hold;
         bus.op_valid = 1'($urandom_range(0, 1));
         bus.op_code = 3'($urandom_range(0, 7));
         if (i == rst_at) begin
            reset = 1'b1;
            bus.fpuhold = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            bus.fpuhold = 1'b0;
            bus.op_valid = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check_idle("reset_abort");
            @(posedge clk); #1;
            return;
         end
      end
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      bus.fpuhold = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bus.busy === 1'b1 || bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_busy_or_done", 1, 0);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("expfunc", int'(bus.expfunc), e.ef);
            chk("safunc", int'(bus.safunc), e.sf);
            chk("done", int'(bus.done), e.dn);
            chk("op_err", int'(bus.op_err), e.er);
            chk("iter", int'(bus.iter), REM_EN ? e.it : 0);
            chk("ready_busy", int'(bus.op_ready), 0);
         end
      end
   end

   initial begin
      int op, nw, rw, hl;
      reset = 1'b1;
      bus.op_valid = 1'b0;
      bus.op_code = '0;
      bus.fpuhold = 1'b0;
      bus.le = 1'b0;
      bus.rsge64 = 1'b0;
      bus.norm_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;

      // Requests under stall must not be taken.
      bus.op_valid = 1'b1;
      bus.fpuhold = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("stall_ready", int'(bus.op_ready), 0);
         @(posedge clk); #1;
      end
      bus.op_valid = 1'b0;
      bus.fpuhold = 1'b0;
      @(negedge clk);
      chk("stall_no_accept", int'(bus.busy), 0);
      @(posedge clk); #1;

      run_op(0, 0, 0, 1, 0, -1, 0, -1);
      run_op(2, 0, 0, 0, 0, -1, 0, -1);
      run_op(3, 0, 0, 0, 0, -1, 0, -1);
      run_op(1, 1, 1, 2, 0, -1, 0, -1);
      run_op(0, 0, 0, 1, 0, 2, 3, -1);
      run_op(4, 0, 0, 0, 5, -1, 0, -1);
      run_op(4, 0, 0, 0, 70, -1, 0, -1);
      run_op(6, 0, 0, 0, 0, -1, 0, -1);
      run_op(0, 0, 0, 60, 0, -1, 0, -1);
      run_op(0, 0, 0, 60, 0, -1, 0, 4);

      for (int t = 0; t < 40; t++) begin
         op = $urandom_range(0, 7);
         nw = ($urandom_range(0, 7) == 0) ? 60 : $urandom_range(0, 6);
         rw = ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(0, 8);
         hl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         run_op(op, $urandom_range(0, 1), $urandom_range(0, 1), nw, rw, -1, hl, -1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            bus.le = 1'($urandom_range(0, 1));
         end
      end

      repeat (3) @(posedge clk);
      chk("queue_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
